// File: rtl/spi_slave_if.sv
// SPI slave pin and parallel-side bundle.
// The master modport is the view of whoever drives the SPI pins and the tx side.
interface spi_slave_if #(
    parameter int unsigned bits_num = 8
) ();
    logic                sclk;
    logic                ss;
    logic                mosi;
    logic                miso;
    logic [bits_num-1:0] tx_data;
    logic                tx_load;
    logic [bits_num-1:0] rx_data;
    logic                rx_valid;
    logic                busy;
    logic                abort;

    modport slave (
        input  sclk, ss, mosi, tx_data, tx_load,
        output miso, rx_data, rx_valid, busy, abort
    );

    modport master (
        output sclk, ss, mosi, tx_data, tx_load,
        input  miso, rx_data, rx_valid, busy, abort
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/ss/mosi in the clk domain, deserialises
// mosi into rx_data and serialises the held tx word onto miso, MSB first.
module spi_slave #(
    parameter logic [1:0]  mode     = 2'b00,
    parameter int unsigned bits_num = 8
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);
    localparam int unsigned cnt_w = $clog2(bits_num) + 1;
    localparam logic        cpol  = mode[1];
    localparam logic        cpha  = mode[0];
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(bits_num - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e state_q, state_d;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [bits_num-1:0] tx_shift_q, tx_shift_d;
    logic [bits_num-1:0] rx_shift_q, rx_shift_d;
    logic [bits_num-1:0] hold_q;
    logic [bits_num-1:0] rx_data_q;
    logic                miso_q, miso_d;
    logic                abort_q, abort_d;
    logic                done_q, done_d;
    logic                rx_valid_q;
    logic                busy_q;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;

    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ss_prev & ~ss_sync;

    // Two-flop synchronisers plus one history stage for edge detection.
    // sclk resets to its idle level so release from reset creates no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta <= cpol;
            sclk_sync <= cpol;
            sclk_prev <= cpol;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= bus.sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= bus.ss;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= bus.mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Holding register: written any time, sampled only when a frame is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (bus.tx_load) begin
            hold_q <= bus.tx_data;
        end
    end

    // FSM state, shift registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            miso_q     <= miso_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            rx_valid_q <= done_q;
            busy_q     <= ~ss_sync;
            if (done_q) begin
                rx_data_q <= rx_shift_q;
            end
        end
    end

    // Next-state logic: frame load, per-edge sample/shift, completion and abort.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        miso_d     = miso_q;
        abort_d    = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                if (ss_fall) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (ss_sync) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end else begin
                    tx_shift_d = hold_q;
                    miso_d     = hold_q[bits_num-1];
                    state_d    = StShift;
                end
            end
            StShift: begin
                // ss release wins over a coincident sample edge.
                if (ss_sync) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                    abort_d = (cnt_q != '0);
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[bits_num-2:0], mosi_sync};
                        if (cnt_q == cnt_last) begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            state_d = StLoad;
                        end else begin
                            cnt_d = cnt_q + cnt_w'(1);
                        end
                    end
                    // With no bit sampled yet the MSB loaded in StLoad must stay
                    // on miso: covers the first CPHA=1 leading edge and the
                    // CPHA=0 trailing edge that closes the previous frame.
                    if (shift_edge && (cnt_q != '0)) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[bits_num-2];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.abort    = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one DUT per SPI mode, a shared bit-banged master
// routed to whichever DUT is selected.
module tb_spi_slave;
    localparam int H = 4;  // clk cycles per sclk phase

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       m_sclk = 1'b0;
    logic       m_ss = 1'b1;
    logic       m_mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;

    logic [3:0] miso_a, rxv_a, busy_a, abort_a;
    logic [7:0] rxd_a [4];
    logic       miso_s, rxv_s, busy_s, abort_s;
    logic [7:0] rxd_s;

    int         n_checks = 0;
    int         n_fail = 0;
    int         rxv_cnt = 0;
    int         abort_cnt = 0;
    logic [7:0] rx_log [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_if #(.bits_num(8)) bus ();
        assign bus.sclk    = (sel == 2'(g)) ? m_sclk : g[1];
        assign bus.ss      = (sel == 2'(g)) ? m_ss : 1'b1;
        assign bus.mosi    = m_mosi;
        assign bus.tx_data = tx_data;
        assign bus.tx_load = tx_load;
        spi_slave #(.mode(2'(g)), .bits_num(8)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign miso_a[g]  = bus.miso;
        assign rxv_a[g]   = bus.rx_valid;
        assign busy_a[g]  = bus.busy;
        assign abort_a[g] = bus.abort;
        assign rxd_a[g]   = bus.rx_data;
    end

    assign miso_s  = miso_a[sel];
    assign rxv_s   = rxv_a[sel];
    assign busy_s  = busy_a[sel];
    assign abort_s = abort_a[sel];
    assign rxd_s   = rxd_a[sel];

    // Count rx_valid/abort pulses of the selected DUT and log received words.
    always @(negedge clk) begin
        if (rxv_s) begin
            rx_log[rxv_cnt[3:0]] <= rxd_s;
            rxv_cnt <= rxv_cnt + 1;
        end
        if (abort_s) begin
            abort_cnt <= abort_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half_wait(input bit do_load, input logic [7:0] v);
        if (do_load) begin
            tx_data = v;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (H - 1) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic select(input logic [1:0] m);
        m_ss   = 1'b1;
        m_sclk = m[1];
        sel    = m;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_low();
        m_ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (H) @(negedge clk);
        m_ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master side of nbits bits, MSB first; optional tx_load pulse at bit load_k.
    task automatic xfer(input logic [7:0] tx, input int nbits, input int load_k,
                        input logic [7:0] load_v, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            if (!sel[0]) begin
                m_mosi = tx[7-k];
                half_wait(k == load_k, load_v);
                rx[7-k] = miso_s;
                m_sclk  = ~sel[1];
                half_wait(1'b0, 8'h00);
                m_sclk  = sel[1];
            end else begin
                m_sclk = ~sel[1];
                m_mosi = tx[7-k];
                half_wait(k == load_k, load_v);
                rx[7-k] = miso_s;
                m_sclk  = sel[1];
                half_wait(1'b0, 8'h00);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"}, 32'(miso_s), 32'h0);
        check_eq({tag, "_rx_data"}, 32'(rxd_s), 32'h0);
        check_eq({tag, "_rx_valid"}, 32'(rxv_s), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy_s), 32'h0);
        check_eq({tag, "_abort"}, 32'(abort_s), 32'h0);
    endtask

    initial begin
        logic [7:0] r0, r1;
        int         vb, ab;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 00 basic exchange.
        load_tx(8'hA5);
        vb = rxv_cnt;
        ab = abort_cnt;
        ss_low();
        check_eq("m0_busy_high", 32'(busy_s), 32'h1);
        xfer(8'h3C, 8, -1, 8'h00, r0);
        check_eq("m0_miso_word", 32'(r0), 32'hA5);
        ss_high();
        check_eq("m0_rx_data", 32'(rxd_s), 32'h3C);
        check_eq("m0_rx_valid_pulses", 32'(rxv_cnt - vb), 32'h1);
        check_eq("m0_no_abort", 32'(abort_cnt - ab), 32'h0);
        check_eq("m0_busy_low", 32'(busy_s), 32'h0);

        // Modes 01, 10, 11.
        for (int m = 1; m < 4; m++) begin
            select(2'(m));
            load_tx(8'hC3);
            vb = rxv_cnt;
            ss_low();
            xfer(8'h5A, 8, -1, 8'h00, r0);
            ss_high();
            check_eq($sformatf("m%0d_miso_word", m), 32'(r0), 32'hC3);
            check_eq($sformatf("m%0d_rx_data", m), 32'(rxd_s), 32'h5A);
            check_eq($sformatf("m%0d_rx_valid_pulses", m), 32'(rxv_cnt - vb), 32'h1);
        end

        // Back-to-back frames in mode 00; holding register was last loaded with 0xC3.
        select(2'd0);
        vb = rxv_cnt;
        ss_low();
        xfer(8'h80, 8, 3, 8'h11, r0);
        xfer(8'h01, 8, -1, 8'h00, r1);
        ss_high();
        check_eq("b2b_miso_frame1", 32'(r0), 32'hC3);
        check_eq("b2b_miso_frame2", 32'(r1), 32'h11);
        check_eq("b2b_rx_valid_pulses", 32'(rxv_cnt - vb), 32'h2);
        check_eq("b2b_rx_word1", 32'(rx_log[vb[3:0]]), 32'h80);
        check_eq("b2b_rx_word2", 32'(rx_log[4'(vb + 1)]), 32'h01);

        // Abort after 5 bits, then a clean frame.
        vb = rxv_cnt;
        ab = abort_cnt;
        ss_low();
        xfer(8'h55, 5, -1, 8'h00, r0);
        ss_high();
        check_eq("abort_pulses", 32'(abort_cnt - ab), 32'h1);
        check_eq("abort_no_rx_valid", 32'(rxv_cnt - vb), 32'h0);
        check_eq("abort_rx_data_kept", 32'(rxd_s), 32'h01);
        ss_low();
        xfer(8'h96, 8, -1, 8'h00, r0);
        ss_high();
        check_eq("post_abort_rx_data", 32'(rxd_s), 32'h96);
        check_eq("post_abort_miso_word", 32'(r0), 32'h11);
        check_eq("post_abort_rx_valid", 32'(rxv_cnt - vb), 32'h1);

        // Reset in the middle of a frame.
        ss_low();
        xfer(8'hAA, 3, -1, 8'h00, r0);
        check_eq("pre_reset_busy", 32'(busy_s), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_sclk = 1'b0;
        m_ss   = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        vb = rxv_cnt;
        ss_low();
        xfer(8'hFF, 8, -1, 8'h00, r0);
        ss_high();
        check_eq("after_reset_miso_word", 32'(r0), 32'h00);
        check_eq("after_reset_rx_data", 32'(rxd_s), 32'hFF);
        check_eq("after_reset_rx_valid", 32'(rxv_cnt - vb), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (peripheral) endpoint that answers the team's SPI master across the chip or board boundary. Oversamples the master's sclk/ss/mosi in the local `clk` domain and deserialises mosi into a parallel word. Serialises a preloaded word onto miso, MSB first. Supports all four CPOL/CPHA modes and back-to-back frames within one ss assertion.

## Interface
- `mode`, 2'b00, {CPOL,CPHA}; must match the master's setting.
- `bits_num`, 8, frame width in bits (≥2).
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  serial clock from master, asynchronous to `clk`.
- `ss`  input  1  slave select from master, active-low, asynchronous.
- `mosi`  input  1  serial data from master.
- `miso`  output  1  serial data to master.
- `tx_data`  input  bits_num  word to return in the next frame.
- `tx_load`  input  1  one-cycle strobe; captures `tx_data` into the holding register.
- `rx_data`  output  bits_num  last completely received word.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` updated this cycle.
- `busy`  output  1  high while synchronised ss is low.
- `abort`  output  1  one-cycle pulse; ss deasserted mid-frame.

## Operation
- Synchronisers: two-flop chains on `sclk`, `ss`, `mosi`. One further register on synced sclk for edge detection. Leading edge = rising if CPOL=0, falling if CPOL=1. Trailing edge = the opposite.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift (drive) edge is the other one.
- States:
  - IDLE: synced ss high.
    - `miso`=0, bit counter=0.
    - Synced ss falling → LOAD.
  - LOAD: one cycle.
    - Holding register copied to tx shift register.
    - `miso` ← its MSB.
    - → SHIFT.
  - SHIFT:
    - On each sample edge: rx shift register ← {rx_shift[bits_num-2:0], mosi_s}, counter+1.
    - On each shift edge: tx shift register shifts left, `miso` ← new MSB.
    - CPHA=1: the first leading edge of a frame keeps the MSB already on `miso` and does not shift.
    - When counter reaches bits_num on a sample edge:
      - `rx_data` ← completed word, `rx_valid`=1 next cycle.
      - Counter ← 0.
      - → LOAD (next frame, same ss).
    - Synced ss rising: → IDLE.
      - If counter ≠ 0: `abort` pulses, `rx_data` unchanged, no `rx_valid`.
- Holding register:
  - `tx_load` writes it any time; a frame already in progress is unaffected.
  - Without a new load, the last held value is retransmitted.
  - Reset value 0.
- Counter width $clog2(bits_num)+1; counts 0..bits_num, no wrap beyond.
- ss rising and a sample edge in the same cycle: ss wins; the partial frame aborts.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `abort`=0; state IDLE; holding and shift registers 0.
- Reset mid-frame: immediate return to IDLE with all reset values; master's ss must be reasserted for a new frame.
- Input latency: a pin transition acts at the 3rd `clk` rising edge after it is first captured. That is 2 sync stages plus the edge/action register.
- `rx_valid` follows the final sample-edge action by 1 cycle (4 cycles after capture of the pin edge).
- `miso` MSB valid 4 cycles after ss falling is captured. Master must allow ≥5 `clk` between ss low and the first sclk edge.
- Each sclk high and low phase must be ≥4 `clk` periods (sclk ≤ clk/8). Faster sclk is unsupported.
- `busy` = synced ss inverted, registered; 3 cycles behind the pin.
- `abort` and `rx_valid` are never high in the same cycle.

## Test plan
- Mode 00: `tx_load` with 0xA5, master sends 0x3C, sclk = clk/8 → `miso` bit stream 1,0,1,0,0,1,0,1; `rx_data`=0x3C with a single `rx_valid` pulse; `busy` falls after ss high.
- All modes 01/10/11: same exchange 0xC3↔0x5A → correct words both directions; CPHA=1 captures on the trailing edge.
- Back-to-back: ss held low for 2 frames, `tx_load` 0x11 mid-frame 1, master sends 0x80 then 0x01 → first frame returns the old held value, second returns 0x11; two `rx_valid` pulses, rx 0x80 then 0x01.
- Abort: ss raised after 5 bits → `abort` pulses once, `rx_data` keeps its prior value, no `rx_valid`; next full frame is received correctly.
- Reset asserted at bit 3 → all outputs to reset values in the same cycle; after release, a new frame 0xFF is received correctly with `miso` sending 0x00.
